dmem_result_scanner: RTL and testbench

- Self-checking stage downstream of mips_32. After the program runs, it sweeps a window of data memory and compares each word with a golden ROM.
- Reports pass/fail counts, first failing address and a weighted score, replacing the bench's hand-written per-word checks.
- Sits beside datapath_unit.data_mem. It drives a read-only port on that memory and on a golden ROM, with both addressed in lockstep.

---
 rtl/dmem_result_scanner.sv | 131 +++++++++++++
 tb/tb_dmem_result_scanner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_result_scanner.sv
// dmem_result_scanner: sweeps a data-memory window against a golden ROM and reports counts, first failure and score.
// Define DMEM_SCAN_WEIGHTED_SCORE_EN to weight matches at index >= WEIGHT_START with 5 half-points instead of 2.
module dmem_result_scanner #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int FIRST_ADDR   = 11,
  parameter int NUM_WORDS    = 55,
  parameter int START_DELAY  = 134,
  parameter int CNT_W        = 8,
  parameter int SCORE_W      = 10,
  parameter int WEIGHT_START = 45
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] gold_rdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_count,
  output logic [CNT_W-1:0]  fail_count,
  output logic              first_fail_valid,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic              mismatch_pulse,
  output logic [SCORE_W-1:0] score
);
  typedef enum logic [2:0] {IDLE, WAIT, SCAN, DRAIN, DONE} state_t;
  localparam int IDX_W = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  localparam int DLY_W = START_DELAY > 1 ? $clog2(START_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(START_DELAY > 0 ? START_DELAY - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);
  if (NUM_WORDS < 1 || longint'(FIRST_ADDR) + longint'(NUM_WORDS) > (longint'(1) << ADDR_W) || WEIGHT_START < 0) begin : g_bad_cfg
    $error("dmem_result_scanner: illegal configuration");
  end
  state_t state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [IDX_W-1:0] idx_q, idx_d, cidx_q, cidx_d;
  logic vld_q, vld_d, ffv_q, ffv_d;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
  logic [ADDR_W-1:0] ffa_q, ffa_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0] weight;
  logic [SCORE_W:0] score_sum;
  logic mism;
  assign mism = vld_q && (mem_rdata !== gold_rdata);
`ifdef DMEM_SCAN_WEIGHTED_SCORE_EN
  assign weight = (32'(cidx_q) >= WEIGHT_START) ? 3'd5 : 3'd2;
`else
  assign weight = 3'd2;
`endif
  assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(weight);
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    idx_d   = idx_q;
    cidx_d  = idx_q;
    vld_d   = state_q == SCAN;
    pass_d  = pass_q;
    fail_d  = fail_q;
    ffv_d   = ffv_q;
    ffa_d   = ffa_q;
    score_d = score_q;
    if (vld_q && mism) begin
      fail_d = &fail_q ? fail_q : fail_q + CNT_W'(1);
      ffv_d  = 1'b1;
      ffa_d  = ffv_q ? ffa_q : ADDR_W'(FIRST_ADDR) + ADDR_W'(cidx_q);
    end else if (vld_q) begin
      pass_d  = &pass_q ? pass_q : pass_q + CNT_W'(1);
      score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    end
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = START_DELAY == 0 ? SCAN : WAIT;
        dly_d   = DLY_LOAD;
        idx_d   = '0;
        pass_d  = '0;
        fail_d  = '0;
        ffv_d   = 1'b0;
        ffa_d   = '0;
        score_d = '0;
      end
      WAIT: begin
        state_d = dly_q == '0 ? SCAN : WAIT;
        dly_d   = dly_q == '0 ? dly_q : dly_q - DLY_W'(1);
      end
      SCAN: begin
        state_d = idx_q == IDX_LAST ? DRAIN : SCAN;
        idx_d   = idx_q == IDX_LAST ? idx_q : idx_q + IDX_W'(1);
      end
      DRAIN: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dly_q   <= '0;
      idx_q   <= '0;
      cidx_q  <= '0;
      vld_q   <= 1'b0;
      pass_q  <= '0;
      fail_q  <= '0;
      ffv_q   <= 1'b0;
      ffa_q   <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      idx_q   <= idx_d;
      cidx_q  <= cidx_d;
      vld_q   <= vld_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      ffv_q   <= ffv_d;
      ffa_q   <= ffa_d;
      score_q <= score_d;
    end
  end
  assign mem_rd_en        = state_q == SCAN;
  assign mem_addr         = mem_rd_en ? ADDR_W'(FIRST_ADDR) + ADDR_W'(idx_q) : '0;
  assign busy             = state_q == WAIT || state_q == SCAN || state_q == DRAIN;
  assign done             = state_q == DONE;
  assign pass_count       = pass_q;
  assign fail_count       = fail_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_addr  = ffa_q;
  assign mismatch_pulse   = mism;
  assign score            = score_q;
endmodule

// File: tb/tb_dmem_result_scanner.sv
// tb_dmem_result_scanner: randomized scans of a modelled data memory and golden ROM checked against a counting reference.
module tb_dmem_result_scanner;
  localparam int FIRST = 11, NW = 55, DLY = 134, WS = 45;
`ifdef DMEM_SCAN_WEIGHTED_SCORE_EN
  localparam int W_HI = 5, FULL_SCORE = 140, TWO_FAIL_SCORE = 133;
`else
  localparam int W_HI = 2, FULL_SCORE = 110, TWO_FAIL_SCORE = 106;
`endif
  logic clk = 0, reset = 1, start = 0;
  logic mem_rd_en, busy, done, first_fail_valid, mismatch_pulse;
  logic [7:0] mem_addr, pass_count, fail_count, first_fail_addr;
  logic [31:0] mem_rdata = 0, gold_rdata = 0;
  logic [9:0] score;
  logic [31:0] mem [256];
  logic [31:0] gold [256];
  int passed = 0, total = 0;
  int first_rd, done_c, rd_cnt, addr_err, pulses, bad_pulses;
  int ep, ef, efv, efa, esc;
  dmem_result_scanner dut (
    .clk(clk), .reset(reset), .start(start), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .gold_rdata(gold_rdata), .busy(busy), .done(done),
    .pass_count(pass_count), .fail_count(fail_count), .first_fail_valid(first_fail_valid),
    .first_fail_addr(first_fail_addr), .mismatch_pulse(mismatch_pulse), .score(score)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) begin
    mem_rdata  <= mem[mem_addr];
    gold_rdata <= gold[mem_addr];
  end
  task automatic fill_match();
    for (int i = 0; i < 256; i++) begin
      gold[i] = $urandom;
      mem[i]  = gold[i];
    end
  endtask
  task automatic model();
    ep = 0; ef = 0; efv = 0; efa = 0; esc = 0;
    for (int i = 0; i < NW; i++) begin
      if (mem[FIRST + i] !== gold[FIRST + i]) begin
        if (efv == 0) efa = FIRST + i;
        efv = 1;
        ef++;
      end else begin
        ep++;
        esc += (i >= WS) ? W_HI : 2;
      end
    end
  endtask
  task automatic run_scan(input int extra_start_at);
    logic prev_rd;
    logic [7:0] prev_addr;
    @(negedge clk) start = 1;
    @(posedge clk) #1 start = 0;
    prev_rd = 0; prev_addr = 0;
    first_rd = -1; done_c = -1; rd_cnt = 0; addr_err = 0; pulses = 0; bad_pulses = 0;
    for (int c = 1; c <= 400 && done_c < 0; c++) begin
      @(negedge clk);
      start = (c == extra_start_at);
      if (mem_rd_en) begin
        if (first_rd < 0) first_rd = c;
        if (int'(mem_addr) != FIRST + rd_cnt) addr_err++;
        rd_cnt++;
      end
      if (mismatch_pulse) begin
        pulses++;
        if (!(prev_rd && mem[prev_addr] !== gold[prev_addr])) bad_pulses++;
      end
      if (done) done_c = c;
      prev_rd = mem_rd_en;
      prev_addr = mem_addr;
    end
    start = 0;
    total++; if (done_c < 0) $display("FAIL scan_timeout: done never seen within 400 cycles"); else passed++;
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({busy, done, mem_rd_en, first_fail_valid, mismatch_pulse} !== 5'b0) $display("FAIL reset_flags: got %b expected 00000", {busy, done, mem_rd_en, first_fail_valid, mismatch_pulse}); else passed++;
    total++; if ({pass_count, fail_count, first_fail_addr, mem_addr} !== 32'h0) $display("FAIL reset_counts: got %h expected 0", {pass_count, fail_count, first_fail_addr, mem_addr}); else passed++;
    total++; if (score !== 10'd0) $display("FAIL reset_score: got %0d expected 0", score); else passed++;
    @(negedge clk) reset = 0;
  endtask
  task automatic test_all_match();
    fill_match();
    model();
    run_scan(0);
    total++; if (first_rd != DLY + 1) $display("FAIL all_match.first_rd_cycle: got %0d expected %0d", first_rd, DLY + 1); else passed++;
    total++; if (done_c != DLY + NW + 2) $display("FAIL all_match.done_cycle: got %0d expected %0d", done_c, DLY + NW + 2); else passed++;
    total++; if (rd_cnt != NW || addr_err != 0) $display("FAIL all_match.reads: got %0d reads %0d bad addrs expected %0d 0", rd_cnt, addr_err, NW); else passed++;
    total++; if (pass_count !== 8'(NW) || fail_count !== 8'd0) $display("FAIL all_match.counts: got %0d/%0d expected %0d/0", pass_count, fail_count, NW); else passed++;
    total++; if (first_fail_valid !== 1'b0 || pulses != 0) $display("FAIL all_match.no_fail: got ffv %b pulses %0d expected 0 0", first_fail_valid, pulses); else passed++;
    total++; if (score !== 10'(FULL_SCORE) || esc != FULL_SCORE) $display("FAIL all_match.score: got %0d model %0d expected %0d", score, esc, FULL_SCORE); else passed++;
  endtask
  task automatic test_single_fail();
    fill_match();
    gold[16] = 32'hfe400000;
    mem[16]  = 32'hfe400001;
    run_scan(0);
    total++; if (pass_count !== 8'd54 || fail_count !== 8'd1) $display("FAIL single_fail.counts: got %0d/%0d expected 54/1", pass_count, fail_count); else passed++;
    total++; if (first_fail_valid !== 1'b1 || first_fail_addr !== 8'd16) $display("FAIL single_fail.first: got %b/%0d expected 1/16", first_fail_valid, first_fail_addr); else passed++;
    total++; if (pulses != 1 || bad_pulses != 0) $display("FAIL single_fail.pulse: got %0d pulses %0d misplaced expected 1 0", pulses, bad_pulses); else passed++;
  endtask
  task automatic test_two_fail();
    fill_match();
    mem[30] = ~gold[30];
    mem[56] = gold[56] ^ 32'h8000_0000;
    run_scan(0);
    total++; if (first_fail_addr !== 8'd30 || fail_count !== 8'd2) $display("FAIL two_fail.first_and_count: got %0d/%0d expected 30/2", first_fail_addr, fail_count); else passed++;
    total++; if (score !== 10'(TWO_FAIL_SCORE)) $display("FAIL two_fail.score: got %0d expected %0d", score, TWO_FAIL_SCORE); else passed++;
    total++; if (pulses != 2 || bad_pulses != 0) $display("FAIL two_fail.pulses: got %0d pulses %0d misplaced expected 2 0", pulses, bad_pulses); else passed++;
  endtask
  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      fill_match();
      for (int k = $urandom_range(0, 8); k > 0; k--) begin
        int a;
        a = FIRST + $urandom_range(0, NW - 1);
        mem[a] = gold[a] ^ (32'd1 << $urandom_range(0, 31));
      end
      model();
      run_scan(0);
      total++; if (pass_count !== 8'(ep) || fail_count !== 8'(ef)) $display("FAIL random%0d.counts: got %0d/%0d expected %0d/%0d", r, pass_count, fail_count, ep, ef); else passed++;
      total++; if (first_fail_valid !== 1'(efv) || (efv == 1 && first_fail_addr !== 8'(efa))) $display("FAIL random%0d.first: got %b/%0d expected %0d/%0d", r, first_fail_valid, first_fail_addr, efv, efa); else passed++;
      total++; if (score !== 10'(esc)) $display("FAIL random%0d.score: got %0d expected %0d", r, score, esc); else passed++;
      total++; if (pulses != ef || bad_pulses != 0) $display("FAIL random%0d.pulses: got %0d pulses %0d misplaced expected %0d 0", r, pulses, bad_pulses, ef); else passed++;
    end
  endtask
  task automatic test_start_in_wait();
    fill_match();
    mem[40] = ~gold[40];
    model();
    run_scan(50);
    total++; if (first_rd != DLY + 1 || done_c != DLY + NW + 2) $display("FAIL start_in_wait.timing: got %0d/%0d expected %0d/%0d", first_rd, done_c, DLY + 1, DLY + NW + 2); else passed++;
    total++; if (rd_cnt != NW || fail_count !== 8'(ef) || score !== 10'(esc)) $display("FAIL start_in_wait.results: got %0d reads %0d fails %0d score expected %0d %0d %0d", rd_cnt, fail_count, score, NW, ef, esc); else passed++;
  endtask
  task automatic test_back_to_back();
    logic [7:0] p1, f1, a1;
    logic [9:0] s1;
    fill_match();
    mem[FIRST + 7] = ~gold[FIRST + 7];
    mem[FIRST + 50] = ~gold[FIRST + 50];
    model();
    run_scan(0);
    p1 = pass_count; f1 = fail_count; a1 = first_fail_addr; s1 = score;
    repeat (10) @(negedge clk);
    total++; if (done !== 1'b1 || busy !== 1'b0 || pass_count !== p1) $display("FAIL hold_done: got done %b busy %b pass %0d expected 1 0 %0d", done, busy, pass_count, p1); else passed++;
    @(negedge clk) start = 1;
    @(posedge clk) #1 start = 0;
    total++; if (busy !== 1'b1 || done !== 1'b0 || pass_count !== 8'd0 || fail_count !== 8'd0 || score !== 10'd0 || first_fail_valid !== 1'b0) $display("FAIL restart_clear: got busy %b done %b %0d/%0d score %0d ffv %b expected cleared", busy, done, pass_count, fail_count, score, first_fail_valid); else passed++;
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk) reset = 0;
    run_scan(0);
    total++; if (pass_count !== 8'(ep) || fail_count !== 8'(ef) || first_fail_addr !== 8'(efa) || score !== 10'(esc)) $display("FAIL back_to_back.model: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", pass_count, fail_count, first_fail_addr, score, ep, ef, efa, esc); else passed++;
    run_scan(0);
    total++; if (pass_count !== p1 || fail_count !== f1 || first_fail_addr !== a1 || score !== s1) $display("FAIL back_to_back.repeat: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", pass_count, fail_count, first_fail_addr, score, p1, f1, a1, s1); else passed++;
  endtask
  task automatic test_reset_mid_scan();
    int seen, stray;
    fill_match();
    mem[FIRST + 3] = ~gold[FIRST + 3];
    model();
    @(negedge clk) start = 1;
    @(posedge clk) #1 start = 0;
    seen = 0;
    for (int c = 0; c < 300 && seen == 0; c++) begin
      @(negedge clk);
      if (mem_rd_en && mem_addr == 8'(FIRST + 20)) seen = 1;
    end
    total++; if (seen == 0) $display("FAIL mid_reset.reach_index20: got no read of address %0d", FIRST + 20); else passed++;
    reset = 1;
    @(posedge clk) #1;
    total++; if ({busy, done, mem_rd_en, first_fail_valid} !== 4'b0 || pass_count !== 8'd0 || fail_count !== 8'd0 || score !== 10'd0) $display("FAIL mid_reset.cleared: got busy %b done %b rd %b ffv %b %0d/%0d score %0d expected all 0", busy, done, mem_rd_en, first_fail_valid, pass_count, fail_count, score); else passed++;
    @(negedge clk) reset = 0;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_rd_en || busy) stray++;
    end
    total++; if (stray != 0) $display("FAIL mid_reset.idle_after: got %0d active cycles expected 0", stray); else passed++;
    run_scan(0);
    total++; if (addr_err != 0 || rd_cnt != NW || pass_count !== 8'(ep) || first_fail_addr !== 8'(efa)) $display("FAIL mid_reset.rescan: got %0d bad addrs %0d reads pass %0d ffa %0d expected 0 %0d %0d %0d", addr_err, rd_cnt, pass_count, first_fail_addr, NW, ep, efa); else passed++;
  endtask
  task automatic test_start_with_reset();
    @(negedge clk);
    start = 1;
    reset = 1;
    @(posedge clk) #1;
    @(negedge clk);
    start = 0;
    reset = 0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || mem_rd_en !== 1'b0) $display("FAIL start_with_reset: got busy %b done %b rd %b expected 0 0 0", busy, done, mem_rd_en); else passed++;
  endtask
  initial begin
    test_reset();
    test_all_match();
    test_single_fail();
    test_two_fail();
    test_random();
    test_start_in_wait();
    test_back_to_back();
    test_reset_mid_scan();
    test_start_with_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
